// File: rtl/gate_tst_pkg.sv
// Shared state encoding and reference truth tables
// for the gate truth sequencer.
package gate_tst_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_t;

  localparam logic [3:0] TT_AND2  = 4'b1000;
  localparam logic [3:0] TT_OR2   = 4'b1110;
  localparam logic [3:0] TT_XOR2  = 4'b0110;
  localparam logic [3:0] TT_NAND2 = 4'b0111;

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter that holds at zero and
// flags when the settle window has elapsed.
module settle_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (dec && cnt != '0)
      cnt <= cnt - W'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/gate_truth_sequencer.sv
// Sweeps every input vector into a gate, samples its
// output after a settle window and scores it against EXP_TT.
module gate_truth_sequencer
  import gate_tst_pkg::*;
#(
  parameter int                   N_IN   = 2,
  parameter int                   SETTLE = 2,
  parameter logic [(1<<N_IN)-1:0] EXP_TT = TT_AND2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] fail_vec,
  output logic [N_IN-1:0] vec_idx
);

  localparam int TW = $clog2(SETTLE) + 1;
  localparam logic [N_IN-1:0] LAST = '1;

  state_t state, state_nx;

  logic tmr_zero;
  logic accept;
  logic clr, drv, ld, dec, chk, fin;
  logic mis;

  // done is high in the IDLE cycle after a run; a start
  // seen then belongs to the finished run and is dropped
  assign accept = start & ~done;
  assign mis    = dut_out ^ EXP_TT[vec_idx];

  settle_timer #(
    .W(TW)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (ld),
    .dec     (dec),
    .load_val(TW'(SETTLE - 1)),
    .zero    (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (rst)
      state <= ST_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:   if (accept) state_nx = ST_DRIVE;
      ST_DRIVE:  state_nx = ST_SETTLE;
      ST_SETTLE: if (tmr_zero) state_nx = ST_CHECK;
      ST_CHECK:  state_nx = (vec_idx == LAST) ? ST_DONE
                                              : ST_DRIVE;
      ST_DONE:   state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    clr = 1'b0;
    drv = 1'b0;
    ld  = 1'b0;
    dec = 1'b0;
    chk = 1'b0;
    fin = 1'b0;
    unique case (1'b1)
      state == ST_IDLE:   clr = accept;
      state == ST_DRIVE:  begin drv = 1'b1; ld = 1'b1; end
      state == ST_SETTLE: dec = 1'b1;
      state == ST_CHECK:  chk = 1'b1;
      state == ST_DONE:   fin = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dut_in    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_vec  <= '0;
      vec_idx   <= '0;
    end else begin
      done <= fin;
      if (clr) begin
        busy      <= 1'b1;
        err_count <= '0;
        fail_vec  <= '0;
        pass      <= 1'b0;
        vec_idx   <= '0;
      end
      if (drv)
        dut_in <= vec_idx;
      if (chk) begin
        if (mis) begin
          err_count <= err_count + (N_IN+1)'(1);
          if (err_count == '0)
            fail_vec <= vec_idx;
        end
        if (vec_idx != LAST)
          vec_idx <= vec_idx + N_IN'(1);
      end
      if (fin) begin
        busy   <= 1'b0;
        pass   <= (err_count == '0);
        dut_in <= '0;
      end
    end
  end

endmodule

// File: tb/tb_gate_truth_sequencer.sv
// Randomized scoreboard bench: stimulus queues expected
// run results, a negedge monitor checks them.
module tb_gate_truth_sequencer;
  import gate_tst_pkg::*;

  localparam int N_IN   = 2;
  localparam int SETTLE = 2;
  localparam int NV     = 1 << N_IN;
  localparam int HOLD   = SETTLE + 2;
  localparam int RUN    = NV * HOLD + 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            dut_out;
  logic [N_IN-1:0] dut_in;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_count;
  logic [N_IN-1:0] fail_vec;
  logic [N_IN-1:0] vec_idx;

  logic [NV-1:0] gate_tt = TT_AND2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int err;
    int fvec;
    int pass;
    int s;
  } exp_t;

  exp_t q[$];

  gate_truth_sequencer #(
    .N_IN  (N_IN),
    .SETTLE(SETTLE),
    .EXP_TT(TT_AND2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dut_in   (dut_in),
    .dut_out  (dut_out),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .err_count(err_count),
    .fail_vec (fail_vec),
    .vec_idx  (vec_idx)
  );

  assign dut_out = gate_tt[dut_in];

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // expected score of a gate against the AND reference
  function automatic exp_t model(input logic [NV-1:0] gate);
    exp_t e;
    logic [NV-1:0] ref_tt = TT_AND2;
    e.err  = 0;
    e.fvec = 0;
    e.s    = 0;
    for (int k = 0; k < NV; k++) begin
      if (gate[k] != ref_tt[k]) begin
        if (e.err == 0) e.fvec = k;
        e.err++;
      end
    end
    e.pass = (e.err == 0) ? 1 : 0;
    return e;
  endfunction

  always @(negedge clk) begin
    int n;
    if (!rst) begin
      if (q.size() > 0) begin
        n = cyc - q[0].s;
        if (n == 1) begin
          chk("clr_err", int'(err_count), 0);
          chk("clr_fvec", int'(fail_vec), 0);
          chk("clr_pass", int'(pass), 0);
        end
        if (n >= 1 && n < RUN) begin
          chk("dut_in", int'(dut_in), (n - 1) / HOLD);
          chk("busy_run", int'(busy), 1);
          chk("done_early", int'(done), 0);
        end
        if (n >= RUN) begin
          chk("done_latency", int'(done), 1);
          chk("busy_end", int'(busy), 0);
          chk("err_count", int'(err_count), q[0].err);
          chk("fail_vec", int'(fail_vec), q[0].fvec);
          chk("pass", int'(pass), q[0].pass);
          chk("dut_in_end", int'(dut_in), 0);
          void'(q.pop_front());
        end
      end else begin
        chk("idle_done", int'(done), 0);
        chk("idle_busy", int'(busy), 0);
      end
    end
  end

  // mode 0 plain, 1 extra start mid-run, 2 start held in done cycle
  task automatic run(input logic [NV-1:0] tt, input int mode);
    exp_t e;
    int s;
    @(posedge clk);
    #1;
    gate_tt = tt;
    e = model(tt);
    s = cyc + 1;
    e.s = s;
    q.push_back(e);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    while (cyc < s + RUN + 2) begin
      @(posedge clk);
      #1;
      start = (mode == 1 && cyc == s + 5) ||
              (mode == 2 && cyc == s + RUN);
    end
    start = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_dut_in"}, int'(dut_in), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_pass"}, int'(pass), 0);
    chk({tag, "_err"}, int'(err_count), 0);
    chk({tag, "_fvec"}, int'(fail_vec), 0);
    chk({tag, "_vec_idx"}, int'(vec_idx), 0);
  endtask

  task automatic reset_mid();
    exp_t e;
    int s;
    @(posedge clk);
    #1;
    gate_tt = TT_AND2;
    e = model(TT_AND2);
    s = cyc + 1;
    e.s = s;
    q.push_back(e);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    // reset lands while vector 2 is settling
    while (cyc < s + 2 * HOLD + 1) begin
      @(posedge clk);
      #1;
    end
    q.delete();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_zero("rst_mid");
    repeat (RUN + 3) @(posedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_zero("reset");
    run(TT_AND2, 0);
    run(4'b0000, 0);
    run(TT_OR2, 0);
    run(TT_AND2, 1);
    reset_mid();
    run(TT_AND2, 0);
    run(TT_XOR2, 0);
    run(TT_AND2, 2);
    run(TT_NAND2, 0);
    for (int i = 0; i < 6; i++)
      run(NV'($urandom), i % 3);
    repeat (4) @(posedge clk);
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
